key_in_hex165: RTL and testbench

//  Serial key-input reader for a chain of 74HC165 parallel-in/serial-out registers. It is the

---
 rtl/key_in_hex165_pkg.sv | 17 +
 rtl/key_in_hex165_debounce.sv | 64 ++++++
 rtl/key_in_hex165.sv | 143 ++++++++++++++
 tb/tb_key_in_hex165.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/key_in_hex165_pkg.sv
// rtl/key_in_hex165_pkg.sv - shared scan states and parameter legality for the 165 key reader
package key_in_hex165_pkg;

    typedef enum logic [2:0] {
        ST_GAP  = 3'd0,
        ST_LOAD = 3'd1,
        ST_LOW  = 3'd2,
        ST_HIGH = 3'd3,
        ST_DONE = 3'd4
    } scan_state_e;

    function automatic bit params_ok(input int n_bits, input int clk_div,
                                     input int scan_gap, input int debounce_scans);
        return (n_bits >= 1) && (clk_div >= 4) && (scan_gap >= 1) && (debounce_scans >= 1);
    endfunction

endpackage

// File: rtl/key_in_hex165_debounce.sv
// rtl/key_in_hex165_debounce.sv - one key bit: scan-count debounce with press/release pulses
module key_debounce #(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic scan_en,
    input  logic raw,
    output logic key,
    output logic key_press,
    output logic key_release
);
    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          prev_q, prev_d;
    logic          key_q, key_d;
    logic          press_q, press_d;
    logic          release_q, release_d;

    always_comb begin
        cnt_d     = cnt_q;
        prev_d    = prev_q;
        key_d     = key_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        if (scan_en) begin
            if (raw != prev_q) begin
                cnt_d = CW'(1);
            end else if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
            end
            prev_d = raw;
            // accept on the scan that completes the run, in the same cycle as the pulse
            if ((cnt_d >= CNT_MAX) && (raw != key_q)) begin
                key_d     = raw;
                press_d   = raw;
                release_d = ~raw;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            prev_q    <= 1'b0;
            key_q     <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            prev_q    <= prev_d;
            key_q     <= key_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign key         = key_q;
    assign key_press   = press_q;
    assign key_release = release_q;

endmodule

// File: rtl/key_in_hex165.sv
// rtl/key_in_hex165.sv - 74HC165 chain scanner: load/shift sequencing, sync, per-bit debounce
module key_in_hex165
    import key_in_hex165_pkg::*;
#(
    parameter int N_BITS         = 16,
    parameter int CLK_DIV        = 25,
    parameter int SCAN_GAP       = 100,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    output logic              sr_clk,
    output logic              sr_ld_n,
    input  logic              sr_dat,
    output logic [N_BITS-1:0] keys,
    output logic [N_BITS-1:0] key_press,
    output logic [N_BITS-1:0] key_release,
    output logic              scan_done
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(SCAN_GAP + 1);
    localparam int IDX_W = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    if (!params_ok(N_BITS, CLK_DIV, SCAN_GAP, DEBOUNCE_SCANS)) begin : g_bad_params
        $error("key_in_hex165: illegal parameter set");
    end

    scan_state_e       state_q, state_d;
    logic [DIV_W-1:0]  div_q, div_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [N_BITS-1:0] raw_q, raw_d;
    logic              sync1_q, sync1_d, sync2_q, sync2_d;
    logic              sr_clk_q, sr_clk_d;
    logic              sr_ld_n_q, sr_ld_n_d;
    logic              scan_done_q, scan_done_d;
    logic              tick_en;

    assign tick_en = (div_q == DIV_W'(CLK_DIV - 1));

    always_comb begin
        sync1_d = sr_dat;
        sync2_d = sync1_q;
        // divider pauses in DONE so every scan, including its DONE cycle, has the same period
        div_d = div_q;
        if (state_q != ST_DONE) begin
            div_d = tick_en ? '0 : div_q + DIV_W'(1);
        end

        state_d     = state_q;
        gap_d       = gap_q;
        idx_d       = idx_q;
        raw_d       = raw_q;
        scan_done_d = 1'b0;
        case (state_q)
            ST_GAP: begin
                if (tick_en) begin
                    if (gap_q == GAP_W'(SCAN_GAP - 1)) begin
                        gap_d   = '0;
                        state_d = ST_LOAD;
                    end else begin
                        gap_d = gap_q + GAP_W'(1);
                    end
                end
            end
            ST_LOAD: begin
                if (tick_en) begin
                    idx_d   = IDX_W'(N_BITS - 1);
                    state_d = ST_LOW;
                end
            end
            ST_LOW: begin
                if (tick_en) begin
                    raw_d[idx_q] = ~sync2_q;
                    state_d      = ST_HIGH;
                end
            end
            ST_HIGH: begin
                if (tick_en) begin
                    if (idx_q == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = ST_LOW;
                    end
                end
            end
            ST_DONE: begin
                scan_done_d = 1'b1;
                state_d     = ST_GAP;
            end
            default: state_d = ST_GAP;
        endcase

        sr_ld_n_d = (state_d != ST_LOAD);
        sr_clk_d  = (state_d == ST_HIGH);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_GAP;
            div_q       <= '0;
            gap_q       <= '0;
            idx_q       <= '0;
            raw_q       <= '0;
            sync1_q     <= 1'b1;
            sync2_q     <= 1'b1;
            sr_clk_q    <= 1'b0;
            sr_ld_n_q   <= 1'b1;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            gap_q       <= gap_d;
            idx_q       <= idx_d;
            raw_q       <= raw_d;
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            sr_clk_q    <= sr_clk_d;
            sr_ld_n_q   <= sr_ld_n_d;
            scan_done_q <= scan_done_d;
        end
    end

    for (genvar i = 0; i < N_BITS; i++) begin : g_bit
        key_debounce #(
            .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
        ) u_debounce (
            .clk        (sys_clk),
            .rst        (sys_rst),
            .scan_en    (state_q == ST_DONE),
            .raw        (raw_q[i]),
            .key        (keys[i]),
            .key_press  (key_press[i]),
            .key_release(key_release[i])
        );
    end

    assign sr_clk    = sr_clk_q;
    assign sr_ld_n   = sr_ld_n_q;
    assign scan_done = scan_done_q;

endmodule

// File: tb/tb_key_in_hex165.sv
// tb/tb_key_in_hex165.sv - bench: two chained 165s, scan-history debounce model, directed vectors
module tb_key_in_hex165;
    import key_in_hex165_pkg::*;

    localparam int NB = 16;
    localparam int CD = 4;
    localparam int SG = 2;
    localparam int DS = 3;
    localparam int PERIOD = CD * (SG + 1 + 2 * NB) + 1;

    if (!params_ok(NB, CD, SG, DS)) begin : g_bad_params
        $error("tb_key_in_hex165: illegal parameter set");
    end

    logic          sys_clk = 1'b0;
    logic          sys_rst = 1'b1;
    logic          sr_clk, sr_ld_n, sr_dat, scan_done;
    logic [NB-1:0] keys, key_press, key_release;

    logic [NB-1:0] pins = '1;
    logic [NB-1:0] sreg = '1;

    int checks = 0;
    int failures = 0;

    always #5 sys_clk = ~sys_clk;

    key_in_hex165 #(
        .N_BITS(NB), .CLK_DIV(CD), .SCAN_GAP(SG), .DEBOUNCE_SCANS(DS)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst    (sys_rst),
        .sr_clk     (sr_clk),
        .sr_ld_n    (sr_ld_n),
        .sr_dat     (sr_dat),
        .keys       (keys),
        .key_press  (key_press),
        .key_release(key_release),
        .scan_done  (scan_done)
    );

    // two chained 165s: Q7 of the last device is pin 15 first; DS tied high
    always @(negedge sr_ld_n or posedge sr_clk) begin
        if (!sr_ld_n) sreg <= pins;
        else          sreg <= {sreg[NB-2:0], 1'b1};
    end
    assign sr_dat = sreg[NB-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // model: keep every scanned vector since reset; a bit is accepted when its trailing run
    // of equal samples reaches DS and differs from the reported key state
    logic [NB-1:0] hist[$];
    logic [NB-1:0] lat_pins = '1;
    logic [NB-1:0] m_keys = '0, m_press = '0, m_rel = '0, raw_v;
    int            cyc = 0, last_done = 0, rises = 0;
    bit            have_last = 0;
    logic          prev_srclk = 1'b0;

    always @(negedge sys_clk) begin
        cyc++;
        if (!sr_ld_n) lat_pins = pins;
        if (sys_rst) begin
            hist.delete();
            m_keys = '0;
            have_last = 0;
            rises = 0;
            prev_srclk = 1'b0;
        end else begin
            if (sr_clk && !prev_srclk) rises++;
            prev_srclk = sr_clk;
            m_press = '0;
            m_rel = '0;
            if (scan_done) begin
                raw_v = ~lat_pins;
                hist.push_back(raw_v);
                for (int i = 0; i < NB; i++) begin
                    int run;
                    run = 0;
                    for (int k = hist.size() - 1; k >= 0; k--) begin
                        if (hist[k][i] !== raw_v[i] || run >= DS) break;
                        run++;
                    end
                    if (run >= DS && raw_v[i] != m_keys[i]) begin
                        m_keys[i] = raw_v[i];
                        if (raw_v[i]) m_press[i] = 1'b1;
                        else          m_rel[i] = 1'b1;
                    end
                end
                chk("sr_clk_rises_per_scan", rises, 16);
                rises = 0;
                if (have_last) chk("scan_done_period", cyc - last_done, PERIOD);
                last_done = cyc;
                have_last = 1;
            end
            chk("keys_vs_model", keys, m_keys);
            chk("press_vs_model", key_press, m_press);
            chk("release_vs_model", key_release, m_rel);
            chk("press_release_overlap", key_press & key_release, 0);
        end
    end

    task automatic do_scans(input int n, output logic [NB-1:0] last_p, output logic [NB-1:0] last_r,
                            output logic [NB-1:0] or_p, output logic [NB-1:0] or_r);
        last_p = '0; last_r = '0; or_p = '0; or_r = '0;
        for (int s = 0; s < n; s++) begin
            int w;
            w = 0;
            do begin
                @(negedge sys_clk);
                w++;
            end while (!scan_done && w < 400);
            if (!scan_done) begin
                checks++;
                failures++;
                $display("FAIL scan_done_timeout waited=%0d cycles required<400", w);
                return;
            end
            last_p = key_press;
            last_r = key_release;
            or_p |= key_press;
            or_r |= key_release;
        end
    endtask

    logic [NB-1:0] lp, lr, op, orr;
    int            first_low, low_len, w;

    initial begin
        sys_rst = 1'b1;
        repeat (3) @(negedge sys_clk);
        chk("rst_sr_ld_n", sr_ld_n, 1);
        chk("rst_sr_clk", sr_clk, 0);
        chk("rst_keys", keys, 0);
        chk("rst_scan_done", scan_done, 0);

        sys_rst = 1'b0;
        first_low = -1;
        low_len = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge sys_clk);
            #1;
            if (!sr_ld_n) begin
                if (first_low < 0) first_low = c;
                low_len++;
            end
        end
        chk("first_load_start", first_low, 8);
        chk("load_pulse_len", low_len, 4);

        do_scans(3, lp, lr, op, orr);
        chk("idle_keys", keys, 16'h0000);
        chk("idle_no_press", op, 16'h0000);

        pins[5] = 1'b0;
        do_scans(2, lp, lr, op, orr);
        chk("pin5_early_press", op, 16'h0000);
        chk("pin5_early_keys", keys, 16'h0000);
        do_scans(1, lp, lr, op, orr);
        chk("pin5_press", lp, 16'h0020);
        chk("pin5_keys", keys, 16'h0020);
        do_scans(3, lp, lr, op, orr);
        chk("pin5_held_press", op, 16'h0000);
        chk("pin5_held_release", orr, 16'h0000);

        pins[5] = 1'b1;
        do_scans(2, lp, lr, op, orr);
        chk("pin5_early_release", orr, 16'h0000);
        do_scans(1, lp, lr, op, orr);
        chk("pin5_release", lr, 16'h0020);
        chk("pin5_released_keys", keys, 16'h0000);

        pins[15] = 1'b0;
        do_scans(2, lp, lr, op, orr);
        pins[15] = 1'b1;
        do_scans(4, lp, lr, op, orr);
        chk("glitch_keys", keys, 16'h0000);
        chk("glitch_press", op, 16'h0000);
        chk("glitch_release", orr, 16'h0000);

        pins[0] = 1'b0;
        pins[15] = 1'b0;
        do_scans(3, lp, lr, op, orr);
        chk("dual_press", lp, 16'h8001);
        chk("dual_keys", keys, 16'h8001);
        pins[0] = 1'b1;
        pins[15] = 1'b1;
        do_scans(3, lp, lr, op, orr);
        chk("dual_release", lr, 16'h8001);

        pins[5] = 1'b0;
        do_scans(3, lp, lr, op, orr);
        chk("pre_reset_keys", keys, 16'h0020);
        w = 0;
        do begin
            @(negedge sys_clk);
            w++;
        end while (!sr_clk && w < 400);
        chk("shift_reached", sr_clk, 1);
        #1 sys_rst = 1'b1;
        #1;
        chk("async_rst_sr_clk", sr_clk, 0);
        chk("async_rst_sr_ld_n", sr_ld_n, 1);
        chk("async_rst_keys", keys, 0);
        chk("async_rst_press", key_press, 0);
        chk("async_rst_release", key_release, 0);
        chk("async_rst_scan_done", scan_done, 0);
        repeat (2) @(negedge sys_clk);
        sys_rst = 1'b0;
        do_scans(2, lp, lr, op, orr);
        chk("rerun_early_press", op, 16'h0000);
        chk("rerun_early_keys", keys, 16'h0000);
        do_scans(1, lp, lr, op, orr);
        chk("rerun_press", lp, 16'h0020);
        chk("rerun_keys", keys, 16'h0020);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout time=%0t required_finish_before=2000000", $time);
        $fatal(1, "timeout");
    end

endmodule
